// File: rtl/pulse_handshake_tx.sv
// Source side of a 4-phase req/ack pulse crossing: queues fast_clk event pulses
// and sends each one as a full handshake. Optional watchdog: PULSE_TX_TIMEOUT_EN.
module pulse_handshake_tx #(
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic             fast_clk,
    input  logic             rst,
    input  logic             fast_os,
    input  logic             ack_async,
    output logic             req,
    output logic [CNT_W-1:0] pending,
    output logic             busy,
    output logic             done_os,
    output logic             overflow,
    output logic             timeout
);
    localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SYNC_N-1:0] r_ack_sync;
    logic [CNT_W-1:0]  r_pending;
    logic              r_req;
    logic              r_done;
    logic              r_overflow;
    logic              w_ack_s;
    logic              w_start;
    logic              w_req_nxt;
    logic              w_done_nxt;

    assign w_ack_s = r_ack_sync[SYNC_N-1];
    assign w_start = (r_state == IDLE) && ((r_pending != '0) || fast_os);

    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_N-2:0], ack_async};
        end
    end

`ifdef PULSE_TX_TIMEOUT_EN
    localparam int unsigned WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [WD_W-1:0] r_wdog;
    logic            r_timeout;
    logic            w_wd_hit;
    logic            w_tmo_set;

    assign w_wd_hit = (r_wdog == WD_W'(TIMEOUT - 1));

    // Reloads on every state change, so it measures time spent in the current phase.
    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            r_wdog <= '0;
        end else if (w_state_nxt != r_state) begin
            r_wdog <= '0;
        end else if (r_state != IDLE) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            r_timeout <= 1'b0;
        end else if (w_tmo_set) begin
            r_timeout <= 1'b1;
        end
    end

    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_done_nxt  = 1'b0;
`ifdef PULSE_TX_TIMEOUT_EN
        w_tmo_set   = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = REQ_HI;
                    w_req_nxt   = 1'b1;
                end
            end
            REQ_HI: begin
                if (w_ack_s) begin
                    w_state_nxt = REQ_LO;
                    w_req_nxt   = 1'b0;
                end
`ifdef PULSE_TX_TIMEOUT_EN
                else if (w_wd_hit) begin
                    w_state_nxt = IDLE;
                    w_req_nxt   = 1'b0;
                    w_tmo_set   = 1'b1;
                end
`endif
            end
            REQ_LO: begin
                if (!w_ack_s) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
`ifdef PULSE_TX_TIMEOUT_EN
                else if (w_wd_hit) begin
                    w_state_nxt = IDLE;
                    w_tmo_set   = 1'b1;
                end
`endif
            end
            default: begin
                w_state_nxt = IDLE;
                w_req_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // A pulse that starts a handshake in the same cycle cancels against the start.
    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            case ({fast_os, w_start})
                2'b10: begin
                    if (&r_pending) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_pending <= r_pending + 1'b1;
                    end
                end
                2'b01:   r_pending <= r_pending - 1'b1;
                default: r_pending <= r_pending;
            endcase
        end
    end

    assign req      = r_req;
    assign pending  = r_pending;
    assign busy     = (r_state != IDLE);
    assign done_os  = r_done;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_pulse_handshake_tx.sv
// Bench for pulse_handshake_tx: two instances (CNT_W=4 and CNT_W=2) share fast_os,
// each with its own delayed-ack receiver, checked every cycle against an event-level model.
module tb_pulse_handshake_tx;
    localparam int SYNC = 2;
    localparam int TMO  = 16;
    localparam int CW0  = 4;
    localparam int CW1  = 2;

    logic           clk   = 1'b0;
    logic           rst   = 1'b1;
    logic           os    = 1'b0;
    logic           stall = 1'b0;
    logic [1:0]     ack   = 2'b00;
    logic [1:0]     req_w, busy_w, done_w, ovf_w, tmo_w;
    logic [CW0-1:0] pend0;
    logic [CW1-1:0] pend1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pulse_handshake_tx #(.CNT_W(CW0), .SYNC_STAGES(SYNC), .TIMEOUT(TMO)) dut0 (
        .fast_clk(clk), .rst(rst), .fast_os(os), .ack_async(ack[0]),
        .req(req_w[0]), .pending(pend0), .busy(busy_w[0]), .done_os(done_w[0]),
        .overflow(ovf_w[0]), .timeout(tmo_w[0]));

    pulse_handshake_tx #(.CNT_W(CW1), .SYNC_STAGES(SYNC), .TIMEOUT(TMO)) dut1 (
        .fast_clk(clk), .rst(rst), .fast_os(os), .ack_async(ack[1]),
        .req(req_w[1]), .pending(pend1), .busy(busy_w[1]), .done_os(done_w[1]),
        .overflow(ovf_w[1]), .timeout(tmo_w[1]));

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int pend_of(input int i);
        return (i == 0) ? int'(pend0) : int'(pend1);
    endfunction

    // ---------------- behavioural model (event level) ----------------
    int          m_max[2]   = '{15, 3};
    int          m_phase[2] = '{0, 0};   // 0 no handshake, 1 waiting ack high, 2 waiting ack low
    int          m_pend[2]  = '{0, 0};
    int          m_rises[2] = '{0, 0};
    int          m_dones[2] = '{0, 0};
    bit          m_req[2]   = '{0, 0};
    bit          m_done[2]  = '{0, 0};
    bit          m_ovf[2]   = '{0, 0};
    bit          m_tmo[2]   = '{0, 0};
    bit [SYNC-1:0] m_ackd[2];            // ack as seen after the synchroniser delay
`ifdef PULSE_TX_TIMEOUT_EN
    int          m_age[2]   = '{0, 0};
`endif

    initial begin
        m_ackd[0] = '0;
        m_ackd[1] = '0;
        forever begin
            @(posedge clk or posedge rst);
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    m_phase[i] = 0; m_pend[i] = 0; m_req[i] = 0; m_done[i] = 0;
                    m_ovf[i] = 0; m_tmo[i] = 0; m_ackd[i] = '0;
                end else begin
                    bit acks;
                    bit start;
                    bit moved;
                    acks      = m_ackd[i][SYNC-1];
                    m_ackd[i] = {m_ackd[i][SYNC-2:0], ack[i]};
                    m_done[i] = 0;
                    moved     = 0;
                    start     = (m_phase[i] == 0) && (m_pend[i] != 0 || os);
                    if (os && !start) begin
                        if (m_pend[i] == m_max[i]) m_ovf[i] = 1;
                        else m_pend[i] = m_pend[i] + 1;
                    end else if (start && !os) begin
                        m_pend[i] = m_pend[i] - 1;
                    end
                    if (m_phase[i] == 0 && start) begin
                        m_phase[i] = 1; m_req[i] = 1; m_rises[i]++; moved = 1;
                    end else if (m_phase[i] == 1 && acks) begin
                        m_phase[i] = 2; m_req[i] = 0; moved = 1;
                    end else if (m_phase[i] == 2 && !acks) begin
                        m_phase[i] = 0; m_done[i] = 1; m_dones[i]++; moved = 1;
                    end
`ifdef PULSE_TX_TIMEOUT_EN
                    if (moved) m_age[i] = 0;
                    else if (m_phase[i] != 0) begin
                        if (m_age[i] == TMO - 1) begin
                            m_phase[i] = 0; m_req[i] = 0; m_tmo[i] = 1; m_age[i] = 0;
                        end else begin
                            m_age[i]++;
                        end
                    end
`else
                    if (moved) m_done[i] = m_done[i];
`endif
                end
            end
        end
    end

    // ---------------- receiver: ack follows req after ~3 cycles unless stalled ----------------
    logic [2:0] rh[2];
    initial begin
        rh[0] = '0;
        rh[1] = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                rh[i]  = {rh[i][1:0], req_w[i]};
                ack[i] = stall ? 1'b0 : rh[i][2];
            end
        end
    end

    // ---------------- per-cycle compare and observation ----------------
    int  rises[2]    = '{0, 0};
    int  dones[2]    = '{0, 0};
    bit  prev_req[2] = '{0, 0};
    int  peak0       = 0;
    time rise_t[2];
    time fall_t[2];

    initial begin
        rise_t[0] = 0; rise_t[1] = 0; fall_t[0] = 0; fall_t[1] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    prev_req[i] = 0;
                end else begin
                    chk($sformatf("u%0d.req", i),      int'(req_w[i]),  int'(m_req[i]));
                    chk($sformatf("u%0d.pending", i),  pend_of(i),      m_pend[i]);
                    chk($sformatf("u%0d.busy", i),     int'(busy_w[i]), int'(m_phase[i] != 0));
                    chk($sformatf("u%0d.done_os", i),  int'(done_w[i]), int'(m_done[i]));
                    chk($sformatf("u%0d.overflow", i), int'(ovf_w[i]),  int'(m_ovf[i]));
                    chk($sformatf("u%0d.timeout", i),  int'(tmo_w[i]),  int'(m_tmo[i]));
                    if (req_w[i] && !prev_req[i]) begin rises[i]++; rise_t[i] = $time; end
                    if (!req_w[i] && prev_req[i]) fall_t[i] = $time;
                    if (done_w[i]) dones[i]++;
                    prev_req[i] = req_w[i];
                end
            end
            if (!rst && int'(pend0) > peak0) peak0 = int'(pend0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse(input int n);
        os = 1'b1;
        repeat (n) tick();
        os = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        os  = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 0;
        for (int n = 0; n < budget && !ok; n++) begin
            tick();
            ok = (m_phase[0] == 0 && m_pend[0] == 0 && m_phase[1] == 0 && m_pend[1] == 0
                  && busy_w == 2'b00);
        end
        if (!ok) chk("wait_idle_expired", 1, 0);
        repeat (2) tick();
    endtask

    int r0, r1, d0, d1;

    initial begin
        // Reset
        stall = 1'b0;
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst.u%0d.req", i),      int'(req_w[i]),  0);
            chk($sformatf("rst.u%0d.pending", i),  pend_of(i),      0);
            chk($sformatf("rst.u%0d.busy", i),     int'(busy_w[i]), 0);
            chk($sformatf("rst.u%0d.done_os", i),  int'(done_w[i]), 0);
            chk($sformatf("rst.u%0d.overflow", i), int'(ovf_w[i]),  0);
            chk($sformatf("rst.u%0d.timeout", i),  int'(tmo_w[i]),  0);
        end
        repeat (10) tick();
        chk("idle.no_req_rise", rises[0] + rises[1], 0);

        // Single event
        r0 = rises[0]; d0 = dones[0];
        pulse(1);
        @(negedge clk);
        chk("single.req_after_1edge", int'(req_w[0]), 1);
        chk("single.pending_bypass", int'(pend0), 0);
        wait_idle(200);
        chk("single.rises", rises[0] - r0, 1);
        chk("single.dones", dones[0] - d0, 1);
        chk("single.busy_after", int'(busy_w[0]), 0);

        // Burst of 5
        do_reset();
        r0 = rises[0]; d0 = dones[0]; r1 = rises[1]; peak0 = 0;
        pulse(5);
        wait_idle(500);
        chk("burst.peak_pending", peak0, 4);
        chk("burst.rises", rises[0] - r0, 5);
        chk("burst.dones", dones[0] - d0, 5);
        chk("burst.overflow", int'(ovf_w[0]), 0);
        chk("burst.cw2_rises", rises[1] - r1, 4);
        chk("burst.cw2_overflow", int'(ovf_w[1]), 1);

        // Saturation with ack stalled
        do_reset();
        r0 = rises[0]; r1 = rises[1];
        stall = 1'b1;
        pulse(6);
        @(negedge clk);
        chk("sat.cw2_pending", int'(pend1), 3);
        chk("sat.cw2_overflow", int'(ovf_w[1]), 1);
        chk("sat.cw4_pending", int'(pend0), 5);
        chk("sat.cw4_overflow", int'(ovf_w[0]), 0);
        stall = 1'b0;
        wait_idle(500);
        chk("sat.cw2_rises", rises[1] - r1, 4);
        chk("sat.cw4_rises", rises[0] - r0, 6);

        // Reset mid-handshake
        do_reset();
        pulse(3);
        @(negedge clk);
        chk("midrst.pre_pending", int'(pend0), 2);
        chk("midrst.pre_busy", int'(busy_w[0]), 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst.req", int'(req_w[0]), 0);
        chk("midrst.pending", int'(pend0), 0);
        chk("midrst.busy", int'(busy_w[0]), 0);
        r0 = rises[0]; d0 = dones[0];
        tick();
        rst = 1'b0;
        repeat (15) tick();
        chk("midrst.no_done", dones[0] - d0, 0);
        chk("midrst.no_restart", rises[0] - r0, 0);

`ifdef PULSE_TX_TIMEOUT_EN
        // Watchdog abort with ack held low
        do_reset();
        r0 = rises[0]; d0 = dones[0];
        stall = 1'b1;
        pulse(1);
        repeat (25) tick();
        chk("tmo.flag", int'(tmo_w[0]), 1);
        chk("tmo.req_high_cycles", int'((fall_t[0] - rise_t[0]) / 10), TMO);
        chk("tmo.no_done", dones[0] - d0, 0);
        chk("tmo.idle", int'(busy_w[0]), 0);
        stall = 1'b0;
        pulse(1);
        wait_idle(200);
        chk("tmo.restart_rises", rises[0] - r0, 2);
        chk("tmo.restart_done", dones[0] - d0, 1);
        chk("tmo.sticky", int'(tmo_w[0]), 1);
`endif

        // Randomised traffic
        do_reset();
        for (int n = 0; n < 600; n++) begin
            os = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 99) < 3) stall = ~stall;
            tick();
        end
        os = 1'b0;
        stall = 1'b0;
        wait_idle(3000);
        chk("rand.u0_rises_total", rises[0], m_rises[0]);
        chk("rand.u0_dones_total", dones[0], m_dones[0]);
        chk("rand.u1_rises_total", rises[1], m_rises[1]);
        chk("rand.u1_dones_total", dones[1], m_dones[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL global_time_limit actual=expired required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pulse_handshake_tx.md
# pulse_handshake_tx

Source-side transmitter for a 4-phase req/ack pulse-crossing handshake. It accepts one-cycle event pulses in the fast_clk domain and queues them in a saturating pending counter. Each event is then delivered across the clock boundary as one full req/ack handshake. The receiver in the other domain returns ack asynchronously; this block synchronizes ack internally, so it needs only one clock.

## Interface
Parameters:
- CNT_W, 4, width of the pending-event counter (saturates at 2^CNT_W-1)
- SYNC_STAGES, 2, flop stages on ack_async (minimum 2)
- TIMEOUT, 64, watchdog limit in fast_clk cycles (used only with PULSE_TX_TIMEOUT_EN)

Ports:
- fast_clk  in  1  sole clock; all state on its rising edge
- rst  in  1  asynchronous, active-high reset
- fast_os  in  1  one-cycle event pulse, synchronous to fast_clk
- ack_async  in  1  ack level from the receiver domain, asynchronous
- req  out  1  registered request level to the receiver domain
- pending  out  CNT_W  queued events not yet started
- busy  out  1  high whenever the state is not IDLE
- done_os  out  1  one-cycle pulse when a handshake completes
- overflow  out  1  sticky; an event was dropped at saturation
- timeout  out  1  sticky watchdog flag (tied 0 without PULSE_TX_TIMEOUT_EN)

## Operation
- ack_s is the output of the SYNC_STAGES flop chain on ack_async. The chain resets to 0.
- FSM states:
  - IDLE: if start (pending!=0 or fast_os), set req<=1 and go to REQ_HI.
  - REQ_HI: wait for ack_s==1, then set req<=0 and go to REQ_LO.
  - REQ_LO: wait for ack_s==0, then go to IDLE and set done_os<=1 for one cycle.
- inc = fast_os. dec = start taken in IDLE.
- Counter rules:
  - inc and dec together: pending unchanged.
  - inc alone: pending+1. If pending is already at max, it holds and overflow<=1.
  - dec alone: pending-1.
- Pending has a bypass path: fast_os arriving in IDLE with pending==0 starts immediately and leaves pending at 0.
- fast_os during REQ_HI or REQ_LO only increments pending. It never disturbs the handshake in progress.
- Exactly one req rising edge per accepted event. Dropped events produce no handshake.
- The FSM returns through IDLE for at least one cycle between handshakes. req is never re-raised in the same edge that enters IDLE.
- overflow and timeout clear only on rst.
- Reset values: req=0, pending=0, busy=0, done_os=0, overflow=0, timeout=0, state=IDLE, sync chain=0.
- rst asserted mid-handshake:
  - Forces all outputs to their reset values immediately (asynchronous). req drops without waiting for ack.
  - Queued events are discarded.

## Timing
- Event to req: fast_os sampled at edge k in IDLE gives req=1 after edge k (1-cycle latency).
- ack_async to FSM reaction: SYNC_STAGES edges after the ack change, plus the decision edge.
- req fall: the edge on which REQ_HI samples ack_s==1.
- done_os: high for exactly the one cycle after the edge that leaves REQ_LO.
- busy is a combinational decode of the state register.
- Minimum handshake period is 2*(SYNC_STAGES+1)+1 cycles plus the receiver's round-trip delay.

## Configuration
- PULSE_TX_TIMEOUT_EN defined:
  - A watchdog counter loads 0 on entry to REQ_HI and again on entry to REQ_LO, and increments every cycle while in either state.
  - On reaching TIMEOUT: req<=0, state<=IDLE, timeout<=1 (sticky), no done_os.
  - The aborted event is not retried. Pending is untouched.
- PULSE_TX_TIMEOUT_EN undefined: no watchdog logic, timeout tied to 0, and the FSM waits on ack indefinitely.

## Test plan
Bench receiver model: ack_async follows req after 3 fast_clk cycles unless stalled.
- Reset: hold rst 3 cycles, then release -> every output 0; 10 idle cycles with no fast_os -> req stays 0.
- Single event: one fast_os pulse -> req=1 one edge later; req falls; exactly one done_os; pending=0 throughout; busy=0 after done_os.
- Burst: 5 fast_os pulses on consecutive cycles -> pending peaks at 4 and decrements once per handshake start; exactly 5 req rising edges; 5 done_os; overflow stays 0.
- Saturation: CNT_W=2, ack stalled low, 6 pulses -> first starts immediately, pending saturates at 3, overflow=1. After ack is released, exactly 4 handshakes run in total.
- Reset mid-handshake: assert rst while in REQ_HI with pending=2 -> req, pending and busy go to 0 before the next edge; no done_os follows.
- Timeout (PULSE_TX_TIMEOUT_EN, TIMEOUT=16): ack held at 0, one pulse -> req drops 16 cycles after it rose; timeout=1; no done_os; a new pulse afterwards still starts a handshake.
